// File: rtl/morse_pkg.sv
// Shared types and constants for the morse receive path.
package morse_pkg;

  localparam int unsigned SYM_W   = 5;
  localparam int unsigned LEN_W   = 3;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned MAX_SYM = 5;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SPACE,
    EMIT,
    GAP
  } state_t;

endpackage

// File: rtl/morse_lut.sv
// Combinational ITU morse lookup: {len, sym} -> ASCII. sym holds the first
// symbol in its most significant used bit; dot = 0, dash = 1.
module morse_lut
  import morse_pkg::*;
(
  input  logic [LEN_W-1:0] len,
  input  logic [SYM_W-1:0] sym,
  output logic             valid,
  output logic [7:0]       ascii
);

  // Pattern decode; anything not listed is reported invalid.
  always_comb begin
    valid = 1'b1;
    ascii = ASCII_QMARK;
    case ({len, sym})
      8'b001_00000: ascii = "E";
      8'b001_00001: ascii = "T";
      8'b010_00000: ascii = "I";
      8'b010_00001: ascii = "A";
      8'b010_00010: ascii = "N";
      8'b010_00011: ascii = "M";
      8'b011_00000: ascii = "S";
      8'b011_00001: ascii = "U";
      8'b011_00010: ascii = "R";
      8'b011_00011: ascii = "W";
      8'b011_00100: ascii = "D";
      8'b011_00101: ascii = "K";
      8'b011_00110: ascii = "G";
      8'b011_00111: ascii = "O";
      8'b100_00000: ascii = "H";
      8'b100_00001: ascii = "V";
      8'b100_00010: ascii = "F";
      8'b100_00100: ascii = "L";
      8'b100_00110: ascii = "P";
      8'b100_00111: ascii = "J";
      8'b100_01000: ascii = "B";
      8'b100_01001: ascii = "X";
      8'b100_01010: ascii = "C";
      8'b100_01011: ascii = "Y";
      8'b100_01100: ascii = "Z";
      8'b100_01101: ascii = "Q";
      8'b101_00000: ascii = "5";
      8'b101_00001: ascii = "4";
      8'b101_00011: ascii = "3";
      8'b101_00111: ascii = "2";
      8'b101_01111: ascii = "1";
      8'b101_10000: ascii = "6";
      8'b101_11000: ascii = "7";
      8'b101_11100: ascii = "8";
      8'b101_11110: ascii = "9";
      8'b101_11111: ascii = "0";
      default:      valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse key decoder: times marks/spaces in ticks, builds a symbol pattern and
// emits ASCII characters plus a space on word gaps.
// Optional: define MORSE_DEC_GLITCH_FILTER_EN to drop marks shorter than a
// quarter unit.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_TICKS     = 200,
  parameter int unsigned DASH_UNITS     = 2,
  parameter int unsigned CHAR_GAP_UNITS = 3,
  parameter int unsigned WORD_GAP_UNITS = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       key_in,
  output logic       char_valid,
  output logic [7:0] char_code,
  output logic       char_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DASH_THR = CNT_W'(DASH_UNITS * UNIT_TICKS);
  localparam logic [CNT_W-1:0] CHAR_THR = CNT_W'(CHAR_GAP_UNITS * UNIT_TICKS);
  localparam logic [CNT_W-1:0] WORD_THR = CNT_W'(WORD_GAP_UNITS * UNIT_TICKS);
`ifdef MORSE_DEC_GLITCH_FILTER_EN
  localparam logic [CNT_W-1:0] GLITCH_THR = CNT_W'(UNIT_TICKS / 4);
`endif

  state_t             state, state_nxt;
  logic               key_s1, key_s2, key_d;
  logic               rise, fall;
  logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [SYM_W-1:0]   sym, sym_nxt;
  logic [LEN_W-1:0]   len, len_nxt;
  logic               ovf, ovf_nxt;
  logic               is_dash;
  logic               valid_nxt, err_nxt;
  logic [7:0]         code_nxt;
  logic               lut_valid;
  logic [7:0]         lut_ascii;

  assign rise    = key_s2 & ~key_d;
  assign fall    = ~key_s2 & key_d;
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  assign is_dash = (cnt >= DASH_THR);

  morse_lut u_lut (
    .len   (len),
    .sym   (sym),
    .valid (lut_valid),
    .ascii (lut_ascii)
  );

  // Synchronizer, edge-detect history and all state/output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1     <= 1'b0;
      key_s2     <= 1'b0;
      key_d      <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      sym        <= '0;
      len        <= '0;
      ovf        <= 1'b0;
      char_valid <= 1'b0;
      char_code  <= 8'h00;
      char_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      key_s1     <= key_in;
      key_s2     <= key_s1;
      key_d      <= key_s2;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sym        <= sym_nxt;
      len        <= len_nxt;
      ovf        <= ovf_nxt;
      char_valid <= valid_nxt;
      char_code  <= code_nxt;
      char_err   <= err_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

  // Next-state, duration counter, symbol store and output decisions.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sym_nxt   = sym;
    len_nxt   = len;
    ovf_nxt   = ovf;
    valid_nxt = 1'b0;
    code_nxt  = char_code;
    err_nxt   = char_err;

    // A key edge restarts timing and swallows a coincident tick.
    if (tick) cnt_nxt = cnt_inc;
    if (rise || fall) cnt_nxt = '0;

    case (state)
      IDLE: begin
        if (rise) state_nxt = MARK;
      end
      MARK: begin
        if (fall) begin
          state_nxt = SPACE;
`ifdef MORSE_DEC_GLITCH_FILTER_EN
          if (cnt < GLITCH_THR) begin
            state_nxt = (len != '0) ? SPACE : IDLE;
          end else if (len == LEN_W'(MAX_SYM)) begin
            ovf_nxt = 1'b1;
          end else begin
            sym_nxt = {sym[SYM_W-2:0], is_dash};
            len_nxt = len + LEN_W'(1);
          end
`else
          if (len == LEN_W'(MAX_SYM)) begin
            ovf_nxt = 1'b1;
          end else begin
            sym_nxt = {sym[SYM_W-2:0], is_dash};
            len_nxt = len + LEN_W'(1);
          end
`endif
        end
      end
      SPACE: begin
        if (rise) begin
          state_nxt = MARK;
        end else if (tick && (cnt_inc >= CHAR_THR)) begin
          // Result is registered here so it is visible during EMIT.
          state_nxt = EMIT;
          valid_nxt = 1'b1;
          if (ovf || !lut_valid) begin
            code_nxt = ASCII_QMARK;
            err_nxt  = 1'b1;
          end else begin
            code_nxt = lut_ascii;
            err_nxt  = 1'b0;
          end
        end
      end
      EMIT: begin
        // Counter keeps running so the word gap is measured from the last mark.
        sym_nxt   = '0;
        len_nxt   = '0;
        ovf_nxt   = 1'b0;
        state_nxt = rise ? MARK : GAP;
      end
      GAP: begin
        if (rise) begin
          state_nxt = MARK;
        end else if (tick && (cnt_inc >= WORD_THR)) begin
          state_nxt = IDLE;
          valid_nxt = 1'b1;
          code_nxt  = ASCII_SPACE;
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder with UNIT_TICKS=4 (dash >= 8 ticks,
// char gap 12, word gap 28). One tick every 4 clocks.
module tb_morse_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       key;
  logic       char_valid;
  logic [7:0] char_code;
  logic       char_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q[$];
  logic [8:0] exp_item;

  morse_decoder #(
    .UNIT_TICKS     (4),
    .DASH_UNITS     (2),
    .CHAR_GAP_UNITS (3),
    .WORD_GAP_UNITS (7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .key_in     (key),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_err   (char_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick_once();
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_once();
  endtask

  task automatic mark(input int n);
    key = 1'b1;
    ticks(n);
    key = 1'b0;
  endtask

  task automatic expect_char(input logic err, input logic [7:0] code);
    exp_q.push_back({err, code});
  endtask

  // Compare every emitted character against the scoreboard.
  always @(negedge clk) begin
    if (!rst && char_valid) begin
      if (exp_q.size() == 0) begin
        check("extra_char_valid", 32'(char_valid), 32'(0));
      end else begin
        exp_item = exp_q.pop_front();
        check("char_code", 32'(char_code), 32'(exp_item[7:0]));
        check("char_err", 32'(char_err), 32'(exp_item[8]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    key  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_char_valid", 32'(char_valid), 32'(0));
    check("rst_char_code", 32'(char_code), 32'h00);
    check("rst_char_err", 32'(char_err), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 'A' = .- with pulse exactly one cycle after the 12th gap tick
    expect_char(1'b0, 8'h41);
    mark(4); ticks(4); mark(12);
    ticks(11);
    check("a_not_early", 32'(char_valid), 32'(0));
    ticks(1);
    check("a_latency", 32'(char_valid), 32'(1));
    check("a_busy", 32'(busy), 32'(1));
    expect_char(1'b0, 8'h20);
    ticks(16);
    check("a_idle_busy", 32'(busy), 32'(0));

    // S O S then word gap
    expect_char(1'b0, 8'h53);
    mark(4); ticks(4); mark(4); ticks(4); mark(4); ticks(12);
    expect_char(1'b0, 8'h4F);
    mark(12); ticks(4); mark(12); ticks(4); mark(12); ticks(12);
    expect_char(1'b0, 8'h53);
    mark(4); ticks(4); mark(4); ticks(4); mark(4); ticks(12);
    expect_char(1'b0, 8'h20);
    ticks(16);
    check("sos_busy", 32'(busy), 32'(0));

    // Six dots overflow, then a single dot decodes as E
    expect_char(1'b1, 8'h3F);
    for (int i = 0; i < 6; i++) begin
      mark(4);
      if (i < 5) ticks(4);
    end
    ticks(12);
    expect_char(1'b0, 8'h45);
    mark(4); ticks(12);
    expect_char(1'b0, 8'h20);
    ticks(16);

    // Five dashes ('0'); first rising edge lands on a tick
    expect_char(1'b0, 8'h30);
    key = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("edge_tick_cnt", 32'(dut.cnt), 32'(0));
    ticks(1);
    check("edge_tick_cnt_next", 32'(dut.cnt), 32'(1));
    ticks(11);
    key = 1'b0;
    ticks(4);
    for (int i = 0; i < 4; i++) begin
      mark(12);
      if (i < 3) ticks(4);
    end
    ticks(12);
    expect_char(1'b0, 8'h20);
    ticks(16);

    // Reset in the middle of the third mark discards the character
    mark(4); ticks(4); mark(4); ticks(4);
    key = 1'b1;
    ticks(2);
    rst = 1'b1;
    key = 1'b0;
    @(negedge clk);
    check("midrst_char_valid", 32'(char_valid), 32'(0));
    check("midrst_char_code", 32'(char_code), 32'h00);
    check("midrst_char_err", 32'(char_err), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    expect_char(1'b0, 8'h45);
    mark(4); ticks(12);
    expect_char(1'b0, 8'h20);
    ticks(16);

    // Three-clock glitch between ticks
`ifndef MORSE_DEC_GLITCH_FILTER_EN
    expect_char(1'b0, 8'h45);
    expect_char(1'b0, 8'h20);
`endif
    key = 1'b1;
    repeat (3) @(negedge clk);
    key = 1'b0;
    ticks(28);
    check("glitch_busy", 32'(busy), 32'(0));

    repeat (5) @(negedge clk);
    check("pending_chars", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morse_decoder.md
Name: morse_decoder

Overview:
Receive-side counterpart of the morse transmit path: measures key mark/space durations in morse units and classifies dots and dashes. Assembles up to 5 symbols per character and emits the decoded ASCII code, plus an ASCII space on word gaps. Runs on the 1 MHz system clock and is timed by a 1 kHz single-cycle enable pulse (tick) from the clock-divider block. Output feeds the display/UART character path.

Parameters:
UNIT_TICKS, 200, ticks per morse unit (200 ms at 1 kHz tick)
DASH_UNITS, 2, mark length in units at or above which a mark is a dash
CHAR_GAP_UNITS, 3, space length in units that ends a character
WORD_GAP_UNITS, 7, space length in units (from end of last mark) that emits a word space
MAX_SYM, 5, maximum symbols per character

Ports:
clk  in  1  1 MHz system clock
rst  in  1  asynchronous, active-high reset
tick  in  1  single-clk-cycle enable, 1 kHz
key_in  in  1  raw key level, 1 = mark; asynchronous to clk
char_valid  out  1  one-cycle pulse, char_code/char_err valid
char_code  out  8  ASCII of decoded character, or 0x20 for a word gap
char_err  out  1  pattern unknown or overflowed; char_code = 0x3F
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset: char_valid=0, char_code=0x00, char_err=0, busy=0, state=IDLE, counter=0, sym=0, len=0, ovf=0.
- key_in passes through a 2-flop synchronizer (reset to 0). Edges are detected on the synchronized level.
- Duration counter: 16-bit, increments only on tick, saturates at 0xFFFF. A key edge in the same cycle as a tick clears the counter to 0; the edge wins and the tick is discarded.
- Symbol store: sym[4:0] shifts left with the new bit at the LSB (dot=0, dash=1). len is 3-bit. An append when len==MAX_SYM sets ovf and leaves sym/len unchanged.
- States:
  - IDLE: rising edge -> MARK, counter cleared.
  - MARK: on falling edge, counter < DASH_UNITS*UNIT_TICKS gives a dot, otherwise a dash. Append the symbol, then -> SPACE with counter cleared.
  - SPACE: rising edge -> MARK with counter cleared (intra-character gap). When the counter reaches CHAR_GAP_UNITS*UNIT_TICKS -> EMIT.
  - EMIT: lasts one cycle. Registers char_valid=1 and char_code=LUT(len,sym). char_err=1 and code 0x3F if ovf or the pattern is unmapped. Clears sym/len/ovf. -> GAP; the counter is NOT cleared.
  - GAP: rising edge -> MARK with counter cleared, no space emitted. When the counter reaches WORD_GAP_UNITS*UNIT_TICKS -> emit char_valid=1, char_code=0x20, char_err=0 for one cycle, then -> IDLE.
- Latency: char_valid is high in the clk cycle after the tick on which the counter reaches the threshold.
- Outputs are registered. char_code/char_err hold their value between pulses.
- A mark held beyond 0xFFFF ticks is still classified as a dash.
- Reset mid-operation discards any partial character; nothing is emitted.
- LUT covers A–Z and 0–9 (ITU). Every other pattern is an error.

Optional Feature:
MORSE_DEC_GLITCH_FILTER_EN
- Defined: a mark with counter < UNIT_TICKS/4 at its falling edge is discarded. No append; return to SPACE with counter cleared if len>0, else IDLE.
- Undefined: every mark is classified, including 0-tick marks (treated as dots).

Decomposition:
- morse_pkg: state encoding (IDLE, MARK, SPACE, EMIT, GAP); constants ASCII_SPACE=0x20, ASCII_QMARK=0x3F, MAX_SYM, SYM_W=5, LEN_W=3, CNT_W=16.
- Sub-module morse_lut: purely combinational, {len,sym} -> {valid, ascii[7:0]}.

Test Plan (UNIT_TICKS=4: dash ≥8 ticks, char gap 12, word gap 28):
1. Mark 4, space 4, mark 12, space 12 ticks -> one char_valid, char_code=0x41 ('A'), char_err=0.
2. S-O-S with 12-tick character gaps, then key low 28 ticks -> pulses 0x53, 0x4F, 0x53, then 0x20, then busy=0.
3. Six 4-tick dots separated by 4-tick spaces, then 12 low -> char_code=0x3F, char_err=1. Next single dot decodes 0x45.
4. Five 12-tick dashes -> char_code=0x30 ('0'). Key edge coincident with a tick -> counter restarts at 0, classification unchanged.
5. rst pulsed mid-mark after 2 symbols -> all outputs 0, no char_valid. A following single dot decodes 0x45.
6. Key high for 3 clk cycles between ticks: with MORSE_DEC_GLITCH_FILTER_EN -> no char_valid and busy returns 0. Without it -> char_valid with 0x45 after the 12-tick gap.
